request_queue: RTL and testbench

Buffers memory requests from the trace parser until the memory-controller scheduler takes them. Each `op_ready_s` strobe with a valid opcode is captured into a circular FIFO of `DEPTH` entries. The head entry is presented to the downstream scheduler through a valid/ready handshake. Every entry carries a saturating age counter so the scheduler can see how long the oldest request has waited. The parser cannot be stalled, so overflow drops the request and raises a sticky error flag.

---
 rtl/request_queue.sv | 123 ++++++++++++
 tb/tb_request_queue.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/request_queue.sv
// Circular request FIFO between the trace parser and the memory-controller scheduler, with per-entry saturating age.
// Latency: a push is visible at the head one cycle after its edge; after a pop the next entry is presented at once.
// Backpressure: the scheduler stalls the head with deq_ready; the parser cannot be stalled, so a push into a full queue is dropped and latches overflow_err.

package request_queue_pkg;
    typedef enum logic [1:0] {
        NOP      = 2'd0,
        READ     = 2'd1,
        WRITE    = 2'd2,
        PREFETCH = 2'd3
    } parsed_op_t;
endpackage

module request_queue
    import request_queue_pkg::*;
#(
    parameter int DEPTH         = 16,
    parameter int ADDRESS_WIDTH = 33,
    parameter int AGE_WIDTH     = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        op_ready_s,
    input  parsed_op_t                  opcode,
    input  logic [ADDRESS_WIDTH-1:0]    address,
    output logic                        deq_valid,
    input  logic                        deq_ready,
    output parsed_op_t                  deq_opcode,
    output logic [ADDRESS_WIDTH-1:0]    deq_address,
    output logic [AGE_WIDTH-1:0]        deq_age,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        full,
    output logic                        empty,
    output logic                        overflow_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]     DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [AGE_WIDTH-1:0] AGE_MAX   = '1;

    typedef struct packed {
        parsed_op_t                 opcode;
        logic [ADDRESS_WIDTH-1:0]   address;
    } entry_t;

    entry_t                 mem     [DEPTH];
    logic [AGE_WIDTH-1:0]   age_mem [DEPTH];
    logic [DEPTH-1:0]       occ;
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W-1:0]       wr_ptr;

    logic push_att;
    logic pop;
    logic push_ok;
    logic push_drop;

    // Handshake decode: a pop frees the slot a same-cycle push needs when full.
    always_comb begin
        push_att  = op_ready_s && (opcode != NOP);
        pop       = deq_valid && deq_ready;
        push_ok   = push_att && (!full || pop);
        push_drop = push_att && full && !pop;
    end

    assign empty     = (count == '0);
    assign full      = (count == DEPTH_CNT);
    assign deq_valid = !empty;

    // Pointers, occupancy count and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            overflow_err <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            if (push_ok && !pop)      count <= count + CNT_W'(1);
            else if (!push_ok && pop) count <= count - CNT_W'(1);
            if (push_drop) overflow_err <= 1'b1;
        end
    end

    // Payload storage; contents are don't-care until the slot is written.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem[wr_ptr] <= '{opcode: opcode, address: address};
        end
    end

    // Per-slot occupancy and age; a write wins over a pop of the same slot (full push+pop).
    always_ff @(posedge clk) begin
        if (rst) begin
            occ <= '0;
            for (int i = 0; i < DEPTH; i++) age_mem[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (push_ok && (wr_ptr == PTR_W'(i))) begin
                    occ[i]     <= 1'b1;
                    age_mem[i] <= '0;
                end else begin
                    if (pop && (rd_ptr == PTR_W'(i))) occ[i] <= 1'b0;
                    if (occ[i] && (age_mem[i] != AGE_MAX)) age_mem[i] <= age_mem[i] + AGE_WIDTH'(1);
                end
            end
        end
    end

    // Head presentation; an empty queue shows a NOP at address 0 with age 0.
    always_comb begin
        deq_opcode  = NOP;
        deq_address = '0;
        deq_age     = '0;
        if (!empty) begin
            deq_opcode  = mem[rd_ptr].opcode;
            deq_address = mem[rd_ptr].address;
            deq_age     = age_mem[rd_ptr];
        end
    end

endmodule

// File: tb/tb_request_queue.sv
module tb_request_queue;
    import request_queue_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_ready_s;
    parsed_op_t  opcode;
    logic [32:0] address;
    logic        deq_valid;
    logic        deq_ready;
    parsed_op_t  deq_opcode;
    logic [32:0] deq_address;
    logic [7:0]  deq_age;
    logic [4:0]  count;
    logic        full;
    logic        empty;
    logic        overflow_err;

    int n_checks = 0;
    int n_fail   = 0;

    request_queue #(.DEPTH(16), .ADDRESS_WIDTH(33), .AGE_WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .op_ready_s   (op_ready_s),
        .opcode       (opcode),
        .address      (address),
        .deq_valid    (deq_valid),
        .deq_ready    (deq_ready),
        .deq_opcode   (deq_opcode),
        .deq_address  (deq_address),
        .deq_age      (deq_age),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    // One rising edge, then settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cycle(input parsed_op_t op, input logic [32:0] a, input logic rdy);
        op_ready_s = 1'b1;
        opcode     = op;
        address    = a;
        deq_ready  = rdy;
        tick();
        op_ready_s = 1'b0;
        opcode     = NOP;
        address    = '0;
        deq_ready  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; op_ready_s = 1'b0; opcode = NOP; address = '0; deq_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        n_checks++; if (count !== 5'd0)        begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
        n_checks++; if (empty !== 1'b1)        begin n_fail++; $display("FAIL reset_empty got %b want 1", empty); end
        n_checks++; if (full !== 1'b0)         begin n_fail++; $display("FAIL reset_full got %b want 0", full); end
        n_checks++; if (deq_valid !== 1'b0)    begin n_fail++; $display("FAIL reset_valid got %b want 0", deq_valid); end
        n_checks++; if (deq_opcode !== NOP)    begin n_fail++; $display("FAIL reset_opcode got %0d want 0", deq_opcode); end
        n_checks++; if (deq_address !== 33'd0) begin n_fail++; $display("FAIL reset_address got %h want 0", deq_address); end
        n_checks++; if (deq_age !== 8'd0)      begin n_fail++; $display("FAIL reset_age got %0d want 0", deq_age); end
        n_checks++; if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", overflow_err); end
    endtask

    task automatic test_push_pop();
        push_cycle(READ, 33'h1_0000_0040, 1'b0);
        n_checks++; if (deq_valid !== 1'b1)              begin n_fail++; $display("FAIL pp_valid got %b want 1", deq_valid); end
        n_checks++; if (deq_address !== 33'h1_0000_0040) begin n_fail++; $display("FAIL pp_address got %h want 100000040", deq_address); end
        n_checks++; if (deq_opcode !== READ)             begin n_fail++; $display("FAIL pp_opcode got %0d want 1", deq_opcode); end
        n_checks++; if (count !== 5'd1)                  begin n_fail++; $display("FAIL pp_count got %0d want 1", count); end
        n_checks++; if (deq_age !== 8'd0)                begin n_fail++; $display("FAIL pp_age got %0d want 0", deq_age); end
        deq_ready = 1'b1;
        tick();
        deq_ready = 1'b0;
        n_checks++; if (empty !== 1'b1)     begin n_fail++; $display("FAIL pp_empty got %b want 1", empty); end
        n_checks++; if (deq_opcode !== NOP) begin n_fail++; $display("FAIL pp_nop got %0d want 0", deq_opcode); end
        // Push with deq_ready high into an empty queue: only the push happens.
        push_cycle(WRITE, 33'h0_0000_0abc, 1'b1);
        n_checks++; if (count !== 5'd1)              begin n_fail++; $display("FAIL empty_bnd_count got %0d want 1", count); end
        n_checks++; if (deq_address !== 33'h0_0000_0abc) begin n_fail++; $display("FAIL empty_bnd_addr got %h want abc", deq_address); end
        deq_ready = 1'b1;
        tick();
        deq_ready = 1'b0;
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL empty_bnd_drain got %b want 1", empty); end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 16; i++) push_cycle((i % 2 == 1) ? WRITE : READ, 33'(i), 1'b0);
        n_checks++; if (full !== 1'b1)    begin n_fail++; $display("FAIL fill_full got %b want 1", full); end
        n_checks++; if (count !== 5'd16)  begin n_fail++; $display("FAIL fill_count got %0d want 16", count); end
        n_checks++; if (deq_age !== 8'd15) begin n_fail++; $display("FAIL fill_head_age got %0d want 15", deq_age); end
        n_checks++; if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL fill_ovf_early got %b want 0", overflow_err); end
        push_cycle(READ, 33'd99, 1'b0);
        n_checks++; if (overflow_err !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b want 1", overflow_err); end
        n_checks++; if (count !== 5'd16)       begin n_fail++; $display("FAIL ovf_count got %0d want 16", count); end
        n_checks++; if (deq_address !== 33'd0) begin n_fail++; $display("FAIL ovf_head got %h want 0", deq_address); end
        deq_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (deq_address !== 33'(i) || deq_valid !== 1'b1) begin
                n_fail++; $display("FAIL drain_order idx %0d got %h valid %b want %h", i, deq_address, deq_valid, 33'(i));
            end
            n_checks++;
            if (deq_opcode !== ((i % 2 == 1) ? WRITE : READ)) begin
                n_fail++; $display("FAIL drain_opcode idx %0d got %0d", i, deq_opcode);
            end
            tick();
        end
        deq_ready = 1'b0;
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty got %b want 1", empty); end
        n_checks++; if (overflow_err !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b want 1", overflow_err); end
    endtask

    task automatic test_full_push_pop();
        logic [32:0] exp_addr;
        do_reset();
        for (int i = 0; i < 16; i++) push_cycle(READ, 33'(100 + i), 1'b0);
        push_cycle(WRITE, 33'd200, 1'b1);
        n_checks++; if (count !== 5'd16)         begin n_fail++; $display("FAIL fpp_count got %0d want 16", count); end
        n_checks++; if (overflow_err !== 1'b0)   begin n_fail++; $display("FAIL fpp_ovf got %b want 0", overflow_err); end
        n_checks++; if (deq_address !== 33'd101) begin n_fail++; $display("FAIL fpp_head got %0d want 101", deq_address); end
        deq_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp_addr = (i == 15) ? 33'd200 : 33'(101 + i);
            n_checks++;
            if (deq_address !== exp_addr) begin
                n_fail++; $display("FAIL fpp_order idx %0d got %0d want %0d", i, deq_address, exp_addr);
            end
            tick();
        end
        deq_ready = 1'b0;
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL fpp_empty got %b want 1", empty); end
    endtask

    task automatic test_wrap();
        logic [32:0] q[$];
        logic [32:0] a;
        int pushes = 0;
        int k = 0;
        logic push_en, pop_en;
        while ((pushes < 40 || q.size() > 0) && k < 400) begin
            push_en = (pushes < 40) && (q.size() < 3) && (k % 5 != 3);
            pop_en  = (q.size() >= 2) || (pushes == 40 && q.size() > 0);
            n_checks++;
            if (count !== 5'(q.size())) begin
                n_fail++; $display("FAIL wrap_count cycle %0d got %0d want %0d", k, count, q.size());
            end
            if (pop_en) begin
                n_checks++;
                if (deq_address !== q[0]) begin
                    n_fail++; $display("FAIL wrap_order cycle %0d got %h want %h", k, deq_address, q[0]);
                end
            end
            a = 33'h1_0000_0000 + 33'(pushes) * 33'd64;
            op_ready_s = push_en;
            opcode     = push_en ? WRITE : NOP;
            address    = a;
            deq_ready  = pop_en;
            tick();
            if (pop_en) void'(q.pop_front());
            if (push_en) begin q.push_back(a); pushes++; end
            k++;
        end
        op_ready_s = 1'b0; opcode = NOP; address = '0; deq_ready = 1'b0;
        n_checks++;
        if (pushes != 40 || q.size() != 0 || empty !== 1'b1) begin
            n_fail++; $display("FAIL wrap_done pushes %0d left %0d empty %b want 40 0 1", pushes, q.size(), empty);
        end
    endtask

    task automatic test_age_nop();
        push_cycle(READ, 33'h1234, 1'b0);
        n_checks++; if (deq_age !== 8'd0) begin n_fail++; $display("FAIL age_start got %0d want 0", deq_age); end
        repeat (10) tick();
        n_checks++; if (deq_age !== 8'd10) begin n_fail++; $display("FAIL age_10 got %0d want 10", deq_age); end
        repeat (140) tick();
        op_ready_s = 1'b1; opcode = NOP; address = 33'h5555;
        tick();
        op_ready_s = 1'b0; address = '0;
        n_checks++; if (count !== 5'd1)        begin n_fail++; $display("FAIL nop_count got %0d want 1", count); end
        n_checks++; if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL nop_ovf got %b want 0", overflow_err); end
        repeat (149) tick();
        n_checks++; if (deq_age !== 8'd255) begin n_fail++; $display("FAIL age_sat got %0d want 255", deq_age); end
        n_checks++; if (deq_address !== 33'h1234) begin n_fail++; $display("FAIL age_head got %h want 1234", deq_address); end
        deq_ready = 1'b1;
        tick();
        deq_ready = 1'b0;
        n_checks++; if (empty !== 1'b1 || deq_age !== 8'd0) begin n_fail++; $display("FAIL age_pop empty %b age %0d want 1 0", empty, deq_age); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 16; i++) push_cycle(WRITE, 33'(300 + i), 1'b0);
        push_cycle(WRITE, 33'd999, 1'b0);
        deq_ready = 1'b1;
        repeat (11) tick();
        deq_ready = 1'b0;
        n_checks++; if (count !== 5'd5 || overflow_err !== 1'b1) begin n_fail++; $display("FAIL mid_pre count %0d ovf %b want 5 1", count, overflow_err); end
        rst = 1'b1; op_ready_s = 1'b1; opcode = READ; address = 33'h77;
        tick();
        rst = 1'b0; op_ready_s = 1'b0; opcode = NOP; address = '0;
        n_checks++; if (count !== 5'd0)        begin n_fail++; $display("FAIL mid_count got %0d want 0", count); end
        n_checks++; if (deq_valid !== 1'b0)    begin n_fail++; $display("FAIL mid_valid got %b want 0", deq_valid); end
        n_checks++; if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL mid_ovf got %b want 0", overflow_err); end
        push_cycle(WRITE, 33'h55, 1'b0);
        n_checks++; if (deq_valid !== 1'b1 || deq_address !== 33'h55) begin n_fail++; $display("FAIL mid_push valid %b addr %h want 1 55", deq_valid, deq_address); end
        n_checks++; if (count !== 5'd1 || deq_opcode !== WRITE) begin n_fail++; $display("FAIL mid_push_cnt count %0d op %0d want 1 2", count, deq_opcode); end
    endtask

    initial begin
        test_reset();
        test_push_pop();
        test_fill_overflow();
        test_full_push_pop();
        test_wrap();
        test_age_nop();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
